// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
// The address check is shared by every redirect path so they all fault the same way.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

    // A fetch target is usable when word aligned and inside the program ROM.
    function automatic logic target_ok(input logic [31:0] addr, input logic [31:0] limit);
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: program ROM port, redirect request from execute and
// the instruction handshake towards decode.
interface instruction_fetch_if;
    logic [31:0] rom_address;
    logic [31:0] rom_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    modport master (
        output rom_address, inst_valid, inst, inst_pc, fetch_fault,
        input  rom_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  rom_address, inst_valid, inst, inst_pc, fetch_fault,
        output rom_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer of {pc, word}; flush wins over push and pop.
// The head entry is read straight from storage so decode sees registered data only.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: walks the program ROM sequentially, buffers up to two
// instructions for decode, follows redirects and halts on bad addresses.
//
// state    | meaning
// ST_IDLE  | one cycle after reset release, no fetch yet
// ST_FETCH | pushing {pc, rom_rdata} whenever the buffer has room
// ST_FAULT | bad target or end of ROM reached; halted until reset
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_DEPTH = 2048
) (
    input  logic                 clock,
    input  logic                 reset,
    instruction_fetch_if.master  bus
);

    localparam logic [31:0] ROM_BYTES = 32'(ROM_DEPTH) * INST_BYTES;

    fetch_state_e state, state_next;
    logic [31:0]  pc, pc_next;
    logic         push, pop, flush, can_pop;
    logic [1:0]   fifo_count;
    fetch_entry_t head, din;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    assign can_pop = (fifo_count != 2'd0) && bus.inst_ready;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    if (target_ok(bus.redirect_pc, ROM_BYTES)) begin
                        pc_next = bus.redirect_pc;
                    end else begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_FETCH: begin
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    if (target_ok(bus.redirect_pc, ROM_BYTES)) begin
                        pc_next = bus.redirect_pc;
                    end else begin
                        state_next = ST_FAULT;
                    end
                end else begin
                    pop = can_pop;
                    // Running off the end of ROM keeps what is already buffered.
                    if (pc >= ROM_BYTES) begin
                        state_next = ST_FAULT;
                    end else if ((fifo_count < 2'd2) || can_pop) begin
                        push    = 1'b1;
                        pc_next = pc + INST_BYTES;
                    end
                end
            end
            ST_FAULT: begin
                pop = can_pop;
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    assign din.pc   = pc;
    assign din.word = bus.rom_rdata;

    fetch_fifo u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .count (fifo_count),
        .head  (head)
    );

    assign bus.rom_address = pc;
    assign bus.inst_valid  = (fifo_count != 2'd0);
    assign bus.inst        = head.word;
    assign bus.inst_pc     = head.pc;
    assign bus.fetch_fault = (state == ST_FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run, checked
// against an in-order program-stream model (next expected pc, ROM word formula).
module tb_instruction_fetch;

    logic clock = 1'b0;
    logic reset = 1'b1;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .ROM_DEPTH (2048)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_model(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    assign bus.rom_rdata = rom_model(bus.rom_address);

    int          checks    = 0;
    int          errors    = 0;
    int          transfers = 0;
    int          beyond    = 0;
    logic [31:0] exp_pc    = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Score the transfer decided by the current inputs, then advance one edge.
    task automatic step();
        logic hs;
        hs = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
        if (hs) begin
            check("order_pc", bus.inst_pc, exp_pc);
            check("order_word", bus.inst, rom_model(exp_pc));
            if (bus.inst_pc >= 32'h2000) beyond++;
            exp_pc = exp_pc + 32'd4;
            transfers++;
        end
        if (bus.redirect_valid) exp_pc = bus.redirect_pc;
        @(posedge clock);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        reset  = 1'b0;
        exp_pc = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] tgt;
        logic [31:0] frozen;
        logic        redir;
        logic        done;
        int          rand_start;

        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b1;

        #3;
        check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        check("rst_fault", {31'b0, bus.fetch_fault}, 32'd0);
        check("rst_rom_addr", bus.rom_address, 32'h0);

        // Streaming from reset with decode always ready.
        release_reset();
        step();
        check("idle_edge_valid", {31'b0, bus.inst_valid}, 32'd0);
        step();
        check("first_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("first_inst_pc", bus.inst_pc, 32'h0);
        for (int i = 0; i < 6; i++) step();

        // Fill the buffer, then reset between edges.
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("full_before_reset", {31'b0, bus.inst_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("async_rst_inst", bus.inst, 32'h0);
        check("async_rst_inst_pc", bus.inst_pc, 32'h0);
        check("async_rst_rom_addr", bus.rom_address, 32'h0);

        // Restart with decode stalled: buffer saturates at two entries.
        release_reset();
        step();
        check("restart_idle_valid", {31'b0, bus.inst_valid}, 32'd0);
        step();
        check("restart_valid", {31'b0, bus.inst_valid}, 32'd1);
        for (int i = 0; i < 3; i++) step();
        check("stall_rom_addr", bus.rom_address, 32'h8);
        check("stall_inst_pc", bus.inst_pc, 32'h0);
        check("stall_inst", bus.inst, rom_model(32'h0));
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("stall_resume_count", transfers, 32'd12);

        // Redirect while full and popping.
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 2; i++) step();
        check("full_before_redirect", bus.rom_address, exp_pc + 32'd8);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        check("redir_bubble", {31'b0, bus.inst_valid}, 32'd0);
        check("redir_rom_addr", bus.rom_address, 32'h40);
        step();
        check("redir_target_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("redir_target_pc", bus.inst_pc, 32'h40);
        step();
        check("redir_next_pc", bus.inst_pc, 32'h44);
        step();

        // Randomized ready and redirects.
        rand_start = transfers;
        for (int i = 0; i < 400; i++) begin
            bus.inst_ready     = ($urandom_range(0, 9) < 7);
            redir              = ($urandom_range(0, 19) == 0);
            tgt                = 32'($urandom_range(0, 1023)) << 2;
            bus.redirect_valid = redir;
            bus.redirect_pc    = tgt;
            step();
            if (redir) begin
                check("rand_redir_bubble", {31'b0, bus.inst_valid}, 32'd0);
                check("rand_redir_addr", bus.rom_address, tgt);
            end
        end
        bus.redirect_valid = 1'b0;
        check("rand_progress", {31'b0, (transfers - rand_start) > 100}, 32'd1);
        check("rand_no_fault", {31'b0, bus.fetch_fault}, 32'd0);

        // Misaligned redirect faults; later redirects are ignored.
        bus.inst_ready = 1'b1;
        step();
        frozen             = bus.rom_address;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h42;
        step();
        check("misalign_fault", {31'b0, bus.fetch_fault}, 32'd1);
        check("misalign_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("misalign_rom_addr", bus.rom_address, frozen);
        bus.redirect_pc = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("fault_sticky", {31'b0, bus.fetch_fault}, 32'd1);
        check("fault_ignore_redir", bus.rom_address, frozen);
        check("fault_no_valid", {31'b0, bus.inst_valid}, 32'd0);

        // Run sequentially off the end of ROM.
        reset = 1'b1;
        #1;
        release_reset();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1F00;
        step();
        bus.redirect_valid = 1'b0;
        beyond = 0;
        done   = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            done = bus.inst_valid && bus.inst_ready && (bus.inst_pc == 32'h1FFC);
            step();
        end
        check("end_last_word_seen", {31'b0, done}, 32'd1);
        check("end_fault", {31'b0, bus.fetch_fault}, 32'd1);
        check("end_no_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("end_rom_addr", bus.rom_address, 32'h2000);
        for (int i = 0; i < 4; i++) step();
        check("end_no_entry_2000", beyond, 32'd0);
        check("end_fault_sticky", {31'b0, bus.fetch_fault}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter ROM_DEPTH, default 2048: number of 32-bit program words.
REQ-003 clock  input  1: sole clock; all state updates on rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 rom_address  output  32: byte address to program ROM; equals pc register, combinational.
REQ-006 rom_rdata  input  32: instruction word returned combinationally for rom_address in the same cycle.
REQ-007 redirect_valid  input  1: branch/jump redirect request from execute stage.
REQ-008 redirect_pc  input  32: redirect target byte address.
REQ-009 inst_valid  output  1: instruction available to decode.
REQ-010 inst_ready  input  1: decode accepts the instruction; transfer when inst_valid && inst_ready.
REQ-011 inst  output  32: instruction word at buffer head.
REQ-012 inst_pc  output  32: byte address of inst.
REQ-013 fetch_fault  output  1: sticky fault flag; fetch halted.

Function
REQ-014 SHALL implement 3-state FSM: IDLE, FETCH, FAULT; IDLE -> FETCH unconditionally on first edge after reset release.
REQ-015 SHALL hold a 2-entry FIFO of {pc, word}; inst_valid = count != 0; inst/inst_pc driven from head entry (registered, no combinational path from rom_rdata).
REQ-016 In FETCH, push {pc, rom_rdata} and pc <= pc + 4 when count < 2, or when count == 2 and a pop occurs the same cycle.
REQ-017 Pop on inst_valid && inst_ready; simultaneous push and pop keeps count unchanged; pushed order preserved.
REQ-018 No push in IDLE or FAULT; pc unchanged when no push.
REQ-019 redirect_valid SHALL take priority over push and pop: FIFO flushed (count <= 0), no pop counted, pc <= redirect_pc, at that edge.
REQ-020 Redirect latency: inst_valid low the cycle after the redirect edge; target instruction valid after the next edge (one bubble).
REQ-021 Redirect target with redirect_pc[1:0] != 0, or redirect_pc >= ROM_DEPTH*4, SHALL enter FAULT: FIFO flushed, fetch_fault <= 1, pc unchanged.
REQ-022 Sequential pc reaching ROM_DEPTH*4 SHALL enter FAULT with no push of the out-of-range address; entries already buffered remain poppable.
REQ-023 FAULT is terminal; only reset exits; redirects ignored in FAULT.
REQ-024 pc arithmetic SHALL be 32-bit unsigned; pc[1:0] always 2'b00.
REQ-025 redirect_valid in IDLE SHALL load pc and still transition to FETCH.

Reset
REQ-026 On reset assertion, immediately: pc = RESET_PC, state = IDLE, count = 0, inst_valid = 0, inst = 0, inst_pc = 0, fetch_fault = 0.
REQ-027 Reset mid-operation SHALL discard all buffered instructions; no partial transfer.
REQ-028 After release, first inst_valid SHALL rise after the second rising edge (IDLE edge, then first push).

Structure
REQ-029 Shared package fetch_pkg SHALL hold the FSM state enum, a fetch-entry struct {pc, word}, and the constant INST_BYTES = 4.
REQ-030 FIFO SHALL be a sub-module fetch_fifo (depth 2, push/pop/flush, count, head outputs).
REQ-031 Block SHALL contain no memory model; it connects to the existing asynchronous ROM via rom_address/rom_rdata.

Verification
REQ-032 Reset release, inst_ready=1, ROM word i = 32'h1000_0000+i -> inst_pc 0,4,8,... on consecutive cycles from edge 2, inst matches.
REQ-033 inst_ready=0 for 5 cycles -> count saturates at 2, pc stops at 8, inst_pc holds 0; on ready=1 sequence 0,4,8 continues with no loss or duplicate.
REQ-034 redirect_valid with redirect_pc=32'h40 while FIFO full and pop active -> FIFO flushed, one bubble, next inst_pc=32'h40, then 32'h44.
REQ-035 redirect_pc=32'h42 -> fetch_fault=1 next cycle, inst_valid=0, rom_address frozen; later redirect to 32'h0 ignored.
REQ-036 Sequential run to pc=ROM_DEPTH*4-4 (32'h1FFC) -> word at 32'h1FFC delivered, then fetch_fault=1, no entry at 32'h2000.
REQ-037 Reset asserted mid-stream with 2 buffered entries -> outputs cleared asynchronously, restart from RESET_PC per REQ-028.
